// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake state plus the cache arbiter's
// FSM state, grant owner and RAM request payload.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned WDOG_W = 8;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE,
      BUSY,
      ACCESS,
      ERROR
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE,
      IGNT,
      DGNT
   } arb_state_t;

   typedef enum logic {
      I,
      D
   } arb_gnt_t;

   typedef struct packed {
      logic  ren;
      logic  wen;
      word_t addr;
      word_t store;
   } ram_req_t;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts granted cycles without RAM progress and flags when
// the count has reached the programmed limit.
module arb_watchdog
   import cpu_types_pkg::*;
#(
   parameter int unsigned CNT_W = WDOG_W
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign expired = (count_q == limit);

endmodule

// File: rtl/cache_arbiter.sv
// Single-port RAM arbiter between icache and dcache. Define CACHE_ARB_RR_EN
// for round-robin on contention; otherwise the dcache has fixed priority.
module cache_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  ramstate_t   ramstate,
   output logic        arb_err
);

   localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYC - 1);

   arb_state_t state_q, state_d;
   ram_req_t   ram_req;
   logic       arb_err_d;
   logic       i_req, d_req, d_first;
   logic       granted, access, abort;
   logic       wdog_expired;

   assign i_req   = iREN;
   assign d_req   = dREN | dWEN;
   assign granted = (state_q != IDLE);
   assign access  = (ramstate == ACCESS);

   // ACCESS always wins; ERROR and timeout abort only an unfinished grant
   assign abort = granted & ~access & ((ramstate == ERROR) | wdog_expired);

   arb_watchdog #(
      .CNT_W (WDOG_W)
   ) u_wdog (
      .CLK     (CLK),
      .nRST    (nRST),
      .clear   (state_q == IDLE),
      .enable  (granted & ~access),
      .limit   (WDOG_LIMIT),
      .expired (wdog_expired)
   );

`ifdef CACHE_ARB_RR_EN
   arb_gnt_t last_gnt_q, last_gnt_d;

   // remember who finished last so the other side wins the next tie
   always_comb begin
      last_gnt_d = last_gnt_q;
      if (granted & (access | abort)) begin
         last_gnt_d = (state_q == IGNT) ? I : D;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         last_gnt_q <= I;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

   assign d_first = d_req & ~(i_req & (last_gnt_q == D));
`else
   assign d_first = d_req;
`endif

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
         arb_err <= 1'b0;
      end else begin
         state_q <= state_d;
         arb_err <= arb_err_d;
      end
   end

   // next state and RAM steering
   always_comb begin
      state_d   = state_q;
      arb_err_d = arb_err;
      ram_req   = '0;
      unique case (state_q)
         IDLE: begin
            if (d_first) begin
               state_d = DGNT;
            end else if (i_req) begin
               state_d = IGNT;
            end
         end
         IGNT: begin
            ram_req.ren  = 1'b1;
            ram_req.addr = iaddr;
            if (access | abort | ~i_req) begin
               state_d = IDLE;
            end
         end
         DGNT: begin
            ram_req.addr  = daddr;
            ram_req.store = dstore;
            ram_req.wen   = dWEN;
            ram_req.ren   = dREN & ~dWEN;
            if (access | abort | ~d_req) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (abort) begin
         arb_err_d = 1'b1;
      end
   end

   assign ramREN   = ram_req.ren;
   assign ramWEN   = ram_req.wen;
   assign ramaddr  = ram_req.addr;
   assign ramstore = ram_req.store;

   assign iwait = i_req & ~((state_q == IGNT) & access);
   assign dwait = d_req & ~((state_q == DGNT) & access);

   assign iload = ramload;
   assign dload = ramload;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: per-cycle stimulus with expected
// outputs queued in a scoreboard and compared mid-cycle.
module tb_cache_arbiter;
   import cpu_types_pkg::*;

   localparam int unsigned TO = 4;
   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;

   logic        CLK;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   ramstate_t   ramstate;
   logic        iwait, dwait, ramREN, ramWEN, arb_err;
   logic [31:0] iload, dload, ramaddr, ramstore;

   typedef struct packed {
      logic        nrst;
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] ds;
      ramstate_t   rs;
      logic [31:0] rl;
   } stim_t;

   typedef struct packed {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
      logic        iw;
      logic        dw;
      logic        err;
      logic [31:0] il;
      logic [31:0] dl;
   } obs_t;

   obs_t obs;
   obs_t sb[$];
   int   n_checks;
   int   n_fail;

   cache_arbiter #(
      .TIMEOUT_CYC (TO)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .arb_err  (arb_err)
   );

   assign obs = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, arb_err, iload, dload};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish in time");
      $fatal(1);
   end

   function automatic stim_t st(logic nrst, logic ir, logic [31:0] ia, logic dr,
                                logic dw, logic [31:0] da, logic [31:0] ds, ramstate_t rs);
      stim_t s;
      s.nrst = nrst; s.ir = ir; s.ia = ia; s.dr = dr; s.dw = dw;
      s.da = da; s.ds = ds; s.rs = rs; s.rl = $urandom;
      return s;
   endfunction

   function automatic obs_t ex(logic ren, logic wen, logic [31:0] addr, logic [31:0] store,
                               logic iw, logic dw, logic err);
      obs_t e;
      e.ren = ren; e.wen = wen; e.addr = addr; e.store = store;
      e.iw = iw; e.dw = dw; e.err = err; e.il = '0; e.dl = '0;
      return e;
   endfunction

   task automatic drive(input stim_t s);
      @(posedge CLK);
      #1;
      nRST = s.nrst; iREN = s.ir; iaddr = s.ia; dREN = s.dr; dWEN = s.dw;
      daddr = s.da; dstore = s.ds; ramstate = s.rs; ramload = s.rl;
   endtask

   task automatic test_reset();
      stim_t s[$]; obs_t x[$]; obs_t e;
      s.push_back(st(N, Y, 32'h44, N, N, 32'h0, 32'h0, FREE)); x.push_back(ex(N, N, 32'h0, 32'h0, Y, N, N));
      s.push_back(st(N, Y, 32'h44, N, N, 32'h0, 32'h0, FREE)); x.push_back(ex(N, N, 32'h0, 32'h0, Y, N, N));
      s.push_back(st(Y, N, 32'h0,  N, N, 32'h0, 32'h0, FREE)); x.push_back(ex(N, N, 32'h0, 32'h0, N, N, N));
      foreach (s[k]) begin
         drive(s[k]);
         e = x[k]; e.il = s[k].rl; e.dl = s[k].rl; sb.push_back(e);
         @(negedge CLK);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reset cyc%0d: got %h expected %h", k, obs, e);
         end
      end
   endtask

   task automatic test_icache_only();
      stim_t s[$]; obs_t x[$]; obs_t e;
      s.push_back(st(Y, Y, 32'h100, N, N, 32'h0, 32'h0, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0, Y, N, N));
      s.push_back(st(Y, Y, 32'h100, N, N, 32'h0, 32'h0, BUSY));   x.push_back(ex(Y, N, 32'h100, 32'h0, Y, N, N));
      s.push_back(st(Y, Y, 32'h100, N, N, 32'h0, 32'h0, BUSY));   x.push_back(ex(Y, N, 32'h100, 32'h0, Y, N, N));
      s.push_back(st(Y, Y, 32'h100, N, N, 32'h0, 32'h0, ACCESS)); x.push_back(ex(Y, N, 32'h100, 32'h0, N, N, N));
      s.push_back(st(Y, N, 32'h0,   N, N, 32'h0, 32'h0, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0, N, N, N));
      foreach (s[k]) begin
         drive(s[k]);
         e = x[k]; e.il = s[k].rl; e.dl = s[k].rl; sb.push_back(e);
         @(negedge CLK);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL icache_only cyc%0d: got %h expected %h", k, obs, e);
         end
      end
   endtask

   task automatic test_contention();
      stim_t s[$]; obs_t x[$]; obs_t e;
      s.push_back(st(Y, Y, 32'h300, Y, N, 32'h200, 32'h11, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0,  Y, Y, N));
      s.push_back(st(Y, Y, 32'h300, Y, N, 32'h200, 32'h11, BUSY));   x.push_back(ex(Y, N, 32'h200, 32'h11, Y, Y, N));
      s.push_back(st(Y, Y, 32'h300, Y, N, 32'h200, 32'h11, ACCESS)); x.push_back(ex(Y, N, 32'h200, 32'h11, Y, N, N));
      s.push_back(st(Y, Y, 32'h300, Y, N, 32'h200, 32'h11, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0,  Y, Y, N));
      s.push_back(st(Y, Y, 32'h300, Y, N, 32'h200, 32'h11, ACCESS));
`ifdef CACHE_ARB_RR_EN
      x.push_back(ex(Y, N, 32'h300, 32'h0, N, Y, N));
`else
      x.push_back(ex(Y, N, 32'h200, 32'h11, Y, N, N));
`endif
      s.push_back(st(Y, N, 32'h0, N, N, 32'h0, 32'h0, FREE));        x.push_back(ex(N, N, 32'h0,   32'h0,  N, N, N));
      foreach (s[k]) begin
         drive(s[k]);
         e = x[k]; e.il = s[k].rl; e.dl = s[k].rl; sb.push_back(e);
         @(negedge CLK);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL contention cyc%0d: got %h expected %h", k, obs, e);
         end
      end
   endtask

   task automatic test_write_beats_read();
      stim_t s[$]; obs_t x[$]; obs_t e;
      s.push_back(st(Y, N, 32'h0, Y, Y, 32'h400, 32'hDEADBEEF, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0,        N, Y, N));
      s.push_back(st(Y, N, 32'h0, Y, Y, 32'h400, 32'hDEADBEEF, BUSY));   x.push_back(ex(N, Y, 32'h400, 32'hDEADBEEF, N, Y, N));
      s.push_back(st(Y, N, 32'h0, Y, Y, 32'h400, 32'hDEADBEEF, ACCESS)); x.push_back(ex(N, Y, 32'h400, 32'hDEADBEEF, N, N, N));
      s.push_back(st(Y, N, 32'h0, N, N, 32'h0,   32'h0,        FREE));   x.push_back(ex(N, N, 32'h0,   32'h0,        N, N, N));
      foreach (s[k]) begin
         drive(s[k]);
         e = x[k]; e.il = s[k].rl; e.dl = s[k].rl; sb.push_back(e);
         @(negedge CLK);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL write_beats_read cyc%0d: got %h expected %h", k, obs, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t s[$]; obs_t x[$]; obs_t e;
      s.push_back(st(Y, N, 32'h0, Y, N, 32'h240, 32'h5, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0, N, Y, N));
      s.push_back(st(Y, N, 32'h0, Y, N, 32'h240, 32'h5, ACCESS)); x.push_back(ex(Y, N, 32'h240, 32'h5, N, N, N));
      s.push_back(st(Y, N, 32'h0, Y, N, 32'h240, 32'h5, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0, N, Y, N));
      s.push_back(st(Y, N, 32'h0, Y, N, 32'h240, 32'h5, ACCESS)); x.push_back(ex(Y, N, 32'h240, 32'h5, N, N, N));
      s.push_back(st(Y, N, 32'h0, N, N, 32'h0,   32'h0, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0, N, N, N));
      foreach (s[k]) begin
         drive(s[k]);
         e = x[k]; e.il = s[k].rl; e.dl = s[k].rl; sb.push_back(e);
         @(negedge CLK);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL back_to_back cyc%0d: got %h expected %h", k, obs, e);
         end
      end
   endtask

   task automatic test_access_at_limit();
      stim_t s[$]; obs_t x[$]; obs_t e;
      s.push_back(st(Y, Y, 32'h510, N, N, 32'h0, 32'h0, FREE)); x.push_back(ex(N, N, 32'h0, 32'h0, Y, N, N));
      for (int c = 0; c < 3; c++) begin
         s.push_back(st(Y, Y, 32'h510, N, N, 32'h0, 32'h0, BUSY)); x.push_back(ex(Y, N, 32'h510, 32'h0, Y, N, N));
      end
      s.push_back(st(Y, Y, 32'h510, N, N, 32'h0, 32'h0, ACCESS)); x.push_back(ex(Y, N, 32'h510, 32'h0, N, N, N));
      s.push_back(st(Y, N, 32'h0,   N, N, 32'h0, 32'h0, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0, N, N, N));
      foreach (s[k]) begin
         drive(s[k]);
         e = x[k]; e.il = s[k].rl; e.dl = s[k].rl; sb.push_back(e);
         @(negedge CLK);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL access_at_limit cyc%0d: got %h expected %h", k, obs, e);
         end
      end
   endtask

   task automatic test_watchdog();
      stim_t s[$]; obs_t x[$]; obs_t e;
      s.push_back(st(Y, Y, 32'h500, N, N, 32'h0, 32'h0, FREE)); x.push_back(ex(N, N, 32'h0, 32'h0, Y, N, N));
      for (int c = 0; c < 4; c++) begin
         s.push_back(st(Y, Y, 32'h500, N, N, 32'h0, 32'h0, BUSY)); x.push_back(ex(Y, N, 32'h500, 32'h0, Y, N, N));
      end
      s.push_back(st(Y, N, 32'h0,   N, N, 32'h0, 32'h0, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0, N, N, Y));
      s.push_back(st(Y, Y, 32'h500, N, N, 32'h0, 32'h0, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0, Y, N, Y));
      s.push_back(st(Y, Y, 32'h500, N, N, 32'h0, 32'h0, ACCESS)); x.push_back(ex(Y, N, 32'h500, 32'h0, N, N, Y));
      s.push_back(st(N, N, 32'h0,   N, N, 32'h0, 32'h0, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0, N, N, Y));
      s.push_back(st(Y, N, 32'h0,   N, N, 32'h0, 32'h0, FREE));   x.push_back(ex(N, N, 32'h0,   32'h0, N, N, N));
      foreach (s[k]) begin
         drive(s[k]);
         e = x[k]; e.il = s[k].rl; e.dl = s[k].rl; sb.push_back(e);
         @(negedge CLK);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL watchdog cyc%0d: got %h expected %h", k, obs, e);
         end
      end
   endtask

   task automatic test_error_withdraw();
      stim_t s[$]; obs_t x[$]; obs_t e;
      s.push_back(st(Y, N, 32'h0,   Y, N, 32'h600, 32'h0, FREE));  x.push_back(ex(N, N, 32'h0,   32'h0, N, Y, N));
      s.push_back(st(Y, N, 32'h0,   Y, N, 32'h600, 32'h0, ERROR)); x.push_back(ex(Y, N, 32'h600, 32'h0, N, Y, N));
      s.push_back(st(Y, N, 32'h0,   N, N, 32'h0,   32'h0, FREE));  x.push_back(ex(N, N, 32'h0,   32'h0, N, N, Y));
      s.push_back(st(N, N, 32'h0,   N, N, 32'h0,   32'h0, FREE));  x.push_back(ex(N, N, 32'h0,   32'h0, N, N, Y));
      s.push_back(st(Y, Y, 32'h700, N, N, 32'h0,   32'h0, FREE));  x.push_back(ex(N, N, 32'h0,   32'h0, Y, N, N));
      s.push_back(st(Y, Y, 32'h700, N, N, 32'h0,   32'h0, BUSY));  x.push_back(ex(Y, N, 32'h700, 32'h0, Y, N, N));
      s.push_back(st(Y, N, 32'h700, N, N, 32'h0,   32'h0, BUSY));  x.push_back(ex(Y, N, 32'h700, 32'h0, N, N, N));
      s.push_back(st(Y, N, 32'h0,   N, N, 32'h0,   32'h0, FREE));  x.push_back(ex(N, N, 32'h0,   32'h0, N, N, N));
      s.push_back(st(Y, N, 32'h0,   N, N, 32'h0,   32'h0, FREE));  x.push_back(ex(N, N, 32'h0,   32'h0, N, N, N));
      foreach (s[k]) begin
         drive(s[k]);
         e = x[k]; e.il = s[k].rl; e.dl = s[k].rl; sb.push_back(e);
         @(negedge CLK);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL error_withdraw cyc%0d: got %h expected %h", k, obs, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t s[$]; obs_t x[$]; obs_t e;
      s.push_back(st(Y, N, 32'h0, Y, N, 32'h800, 32'h9, FREE)); x.push_back(ex(N, N, 32'h0,   32'h0, N, Y, N));
      s.push_back(st(N, N, 32'h0, Y, N, 32'h800, 32'h9, BUSY)); x.push_back(ex(Y, N, 32'h800, 32'h9, N, Y, N));
      s.push_back(st(Y, N, 32'h0, N, N, 32'h0,   32'h0, FREE)); x.push_back(ex(N, N, 32'h0,   32'h0, N, N, N));
      foreach (s[k]) begin
         drive(s[k]);
         e = x[k]; e.il = s[k].rl; e.dl = s[k].rl; sb.push_back(e);
         @(negedge CLK);
         e = sb.pop_front(); n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_mid cyc%0d: got %h expected %h", k, obs, e);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      nRST     = 1'b0;
      iREN     = 1'b0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      iaddr    = '0;
      daddr    = '0;
      dstore   = '0;
      ramload  = '0;
      ramstate = FREE;
      test_reset();
      test_icache_only();
      test_contention();
      test_write_beats_read();
      test_back_to_back();
      test_access_at_limit();
      test_watchdog();
      test_error_withdraw();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
